mem_wb_stage_reg: RTL and testbench
===================================

# mem_wb_stage_reg

Pipeline register between the memory stage and write-back. It captures the memory-stage result, selects the write-back value, and owns the multi-cycle SRAM stall. Whenever a load/store is outstanding and the SRAM controller is not ready, it raises `freeze` to the upstream stages and inserts a write-back bubble. It also keeps a saturating stall counter and a sticky timeout flag for bring-up.

## Interface
Parameters
- `TIMEOUT`, default 32: maximum consecutive stall cycles before `mem_timeout` sets (legal range 2..255).

Ports
- `clk`  in  1  the only clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `WB_EN_in`  in  1  write-back enable from the memory stage.
- `MEM_R_EN_in`  in  1  load in the memory stage (raw, not ready-gated).
- `MEM_W_EN_in`  in  1  store in the memory stage.
- `alu_res_in`  in  32  ALU result / address.
- `mem_data_in`  in  32  SRAM read data; valid when `sram_ready`=1.
- `Dest_in`  in  4  destination register.
- `sram_ready`  in  1  SRAM controller ready/done. High when idle; high for the completing cycle of an access.
- `WB_EN`  out  1  registered write-back enable.
- `MEM_R_EN`  out  1  registered load flag.
- `alu_res`  out  32  registered ALU result.
- `mem_data`  out  32  registered load data.
- `Dest`  out  4  registered destination.
- `WB_Value`  out  32  `MEM_R_EN ? mem_data : alu_res` (combinational from registers).
- `freeze`  out  1  stall request to PC/IF/ID/EXE registers.
- `stall_count`  out  16  saturating count of frozen cycles since reset.
- `mem_timeout`  out  1  sticky; a single stall exceeded `TIMEOUT` cycles.

## Operation
- `mem_op = MEM_R_EN_in | MEM_W_EN_in`.
- `freeze = mem_op & ~sram_ready`. This is combinational, with no register in the path.
- FSM states:
  - IDLE -> BUSY when `freeze`=1.
  - BUSY -> IDLE when `sram_ready`=1 or `mem_op`=0.
  - IDLE -> IDLE otherwise.
- Per-cycle register update:
  - `freeze`=0: load all five fields from the inputs. `MEM_R_EN` loads `MEM_R_EN_in`, so the load is written back exactly once, in the completing cycle.
  - `freeze`=1: load a bubble: `WB_EN`<=0 and `MEM_R_EN`<=0. `alu_res`, `mem_data` and `Dest` hold their values.
- Stores (`MEM_W_EN_in`) stall the same way. A store normally has `WB_EN_in`=0, and this block passes `WB_EN_in` through unmodified.
- Stall counter (`stall_cnt`, 8-bit, internal):
  - Increments while in BUSY.
  - Clears when leaving BUSY.
  - When `stall_cnt == TIMEOUT` in BUSY, `mem_timeout` sets. It stays set until `rst`.
  - `freeze` is not overridden by the timeout; the pipeline keeps waiting.
- `stall_count`: increments by 1 on every edge where `freeze`=1. It saturates at 16'hFFFF and never wraps.
- Back-to-back memory operations: each one independently re-enters BUSY. The completing cycle of op N is never frozen, so op N+1 reaches the memory stage the next cycle.

## Timing
- Reset (async assert, state released on first edge after deassert):
  - all registered outputs 0, FSM IDLE, `stall_cnt`=0, `stall_count`=0, `mem_timeout`=0.
  - `WB_Value`=0.
  - `freeze` follows its combinational equation even during reset.
- Latency: non-memory instruction, 1 cycle from inputs to registered outputs.
- Load completing at edge k: `WB_EN`, `MEM_R_EN`, `mem_data` are visible after edge k. `WB_Value` equals the load data in the same cycle.
- An SRAM access taking N cycles with ready on the Nth produces:
  - N-1 freeze cycles;
  - N-1 bubbles;
  - `stall_count` += N-1.
- `sram_ready`=1 in the first cycle of an op: no freeze, no BUSY entry, behaves as 1-cycle.
- `mem_op` drops while BUSY (flush upstream): return to IDLE, clear `stall_cnt`, no extra bubble.
- Reset asserted mid-stall: immediate return to IDLE with counters cleared. Any partial load is discarded.
- `TIMEOUT` check uses `>=` on the internal counter. The flag sets on the edge where the TIMEOUT-th stall cycle completes.

## Test plan
- Reset, then an ALU op (`WB_EN_in`=1, `alu_res_in`=32'h0000_0010, `Dest_in`=4'd3) with `sram_ready`=1 -> after 1 edge: `WB_EN`=1, `Dest`=3, `WB_Value`=32'h10, `freeze`=0.
- Load, `sram_ready` low for 4 cycles then high with `mem_data_in`=32'hDEAD_BEEF -> `freeze` high for exactly 4 cycles, 4 bubbles with `WB_EN`=0, then `WB_EN`=1, `MEM_R_EN`=1, `WB_Value`=32'hDEAD_BEEF; `stall_count`=4.
- Store with 3 stall cycles, immediately followed by a load with 3 stall cycles -> two separate freeze windows of 3 cycles with one unfrozen cycle between; `stall_count`=6; `WB_EN` pulses once, for the load.
- `TIMEOUT`=8, load with `sram_ready` held low 12 cycles -> `mem_timeout` sets after the 8th stall cycle, `freeze` stays high through all 12 cycles, the load then completes normally.
- `rst` pulsed mid-stall (cycle 2 of 5) -> all outputs 0 asynchronously, FSM IDLE, `mem_timeout`=0, `stall_count`=0.
- Force `stall_count` near saturation (65534 +3 stalls) -> stops at 65535, no wrap.

Source files
------------

// File: rtl/mem_wb_stage_reg_if.sv
// MEM/WB boundary bundle: memory-stage results in, registered write-back
// fields, stall request and bring-up status out.
interface mem_wb_stage_reg_if;
  logic        WB_EN_in;
  logic        MEM_R_EN_in;
  logic        MEM_W_EN_in;
  logic [31:0] alu_res_in;
  logic [31:0] mem_data_in;
  logic [3:0]  Dest_in;
  logic        sram_ready;

  logic        WB_EN;
  logic        MEM_R_EN;
  logic [31:0] alu_res;
  logic [31:0] mem_data;
  logic [3:0]  Dest;
  logic [31:0] WB_Value;
  logic        freeze;
  logic [15:0] stall_count;
  logic        mem_timeout;

  // master: memory stage / write-back consumer side; slave: the stage register
  modport master (
    output WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, alu_res_in, mem_data_in, Dest_in, sram_ready,
    input  WB_EN, MEM_R_EN, alu_res, mem_data, Dest, WB_Value, freeze, stall_count, mem_timeout
  );

  modport slave (
    input  WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, alu_res_in, mem_data_in, Dest_in, sram_ready,
    output WB_EN, MEM_R_EN, alu_res, mem_data, Dest, WB_Value, freeze, stall_count, mem_timeout
  );
endinterface

// File: rtl/mem_wb_stage_reg.sv
// MEM/WB pipeline register that owns the multi-cycle SRAM stall: freezes the
// front of the pipe, inserts write-back bubbles and tracks stall statistics.
module mem_wb_stage_reg #(
  parameter int TIMEOUT = 32
) (
  input logic              clk,
  input logic              rst,
  mem_wb_stage_reg_if.slave bus
);

  localparam int          DATA_W    = 32;
  localparam int          DEST_W    = 4;
  localparam logic [7:0]  TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic                mem_op;
  logic                frz;
  logic [7:0]          stall_cnt_q, stall_cnt_d, stall_cnt_inc;
  logic [15:0]         stall_count_q;
  logic                timeout_q, timeout_d;

  logic                wb_en_p1;
  logic                mem_r_en_p1;
  logic [DATA_W-1:0]   alu_res_p1;
  logic [DATA_W-1:0]   mem_data_p1;
  logic [DEST_W-1:0]   dest_p1;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // freeze is purely combinational so the upstream registers see it in the
  // same cycle the SRAM reports not-ready
  assign mem_op        = bus.MEM_R_EN_in | bus.MEM_W_EN_in;
  assign frz           = mem_op & ~bus.sram_ready;
  assign stall_cnt_inc = sat_inc8(stall_cnt_q);

  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    timeout_d   = timeout_q;
    case (state_q)
      IDLE:    if (frz) state_d = BUSY;
      BUSY:    if (bus.sram_ready || !mem_op) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // stall_cnt holds the number of completed cycles of the current stall
    if (state_d == BUSY) begin
      stall_cnt_d = stall_cnt_inc;
      if (stall_cnt_inc >= TIMEOUT_C) timeout_d = 1'b1;
    end else begin
      stall_cnt_d = '0;
    end
  end

  // control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      stall_cnt_q   <= '0;
      stall_count_q <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
      if (frz) stall_count_q <= sat_inc16(stall_count_q);
    end
  end

  // p1: write-back register; a frozen cycle becomes a bubble, data fields hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_p1    <= 1'b0;
      mem_r_en_p1 <= 1'b0;
      alu_res_p1  <= '0;
      mem_data_p1 <= '0;
      dest_p1     <= '0;
    end else if (frz) begin
      wb_en_p1    <= 1'b0;
      mem_r_en_p1 <= 1'b0;
    end else begin
      wb_en_p1    <= bus.WB_EN_in;
      mem_r_en_p1 <= bus.MEM_R_EN_in;
      alu_res_p1  <= bus.alu_res_in;
      mem_data_p1 <= bus.mem_data_in;
      dest_p1     <= bus.Dest_in;
    end
  end

  assign bus.WB_EN       = wb_en_p1;
  assign bus.MEM_R_EN    = mem_r_en_p1;
  assign bus.alu_res     = alu_res_p1;
  assign bus.mem_data    = mem_data_p1;
  assign bus.Dest        = dest_p1;
  assign bus.WB_Value    = mem_r_en_p1 ? mem_data_p1 : alu_res_p1;
  assign bus.freeze      = frz;
  assign bus.stall_count = stall_count_q;
  assign bus.mem_timeout = timeout_q;

endmodule

// File: tb/tb_mem_wb_stage_reg.sv
// Scoreboard bench for mem_wb_stage_reg: directed ops push expected
// write-backs, a negedge monitor pops and compares each WB_EN pulse.
module tb_mem_wb_stage_reg;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_wb_stage_reg_if bus();

  mem_wb_stage_reg #(.TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [3:0]  dest;
    logic [31:0] value;
    logic        mem_r;
  } wb_t;

  wb_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  // reference state
  int unsigned exp_stall = 0;
  logic        exp_to    = 1'b0;
  logic [31:0] mdl_alu   = '0;
  logic [31:0] mdl_data  = '0;
  logic [3:0]  mdl_dest  = '0;
  logic [31:0] prev_alu  = '0;
  logic [31:0] prev_data = '0;
  logic [3:0]  prev_dest = '0;
  logic        prev_frz  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int unsigned sat16(input int unsigned v);
    return (v > 65535) ? 65535 : v;
  endfunction

  // monitor: every write-back pulse must match the oldest expected entry
  always @(negedge clk) begin
    wb_t e;
    if (rst === 1'b0 && bus.WB_EN === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wb_unexpected actual dest=%0d value=%h required=no_writeback", bus.Dest, bus.WB_Value);
      end else begin
        e = exp_q.pop_front();
        check("wb_dest", 32'(bus.Dest), 32'(e.dest));
        check("wb_value", bus.WB_Value, e.value);
        check("wb_mem_r_en", 32'(bus.MEM_R_EN), 32'(e.mem_r));
      end
    end
  end

  // one cycle of stimulus; also advances the register model for the edge just taken
  task automatic drive(input logic wb, input logic r, input logic w, input logic [31:0] alu,
                       input logic [31:0] data, input logic [3:0] dest, input logic ready);
    @(posedge clk);
    if (!prev_frz) begin
      mdl_alu  = prev_alu;
      mdl_data = prev_data;
      mdl_dest = prev_dest;
    end
    #1;
    bus.WB_EN_in    = wb;
    bus.MEM_R_EN_in = r;
    bus.MEM_W_EN_in = w;
    bus.alu_res_in  = alu;
    bus.mem_data_in = data;
    bus.Dest_in     = dest;
    bus.sram_ready  = ready;
    prev_alu  = alu;
    prev_data = data;
    prev_dest = dest;
    prev_frz  = (r | w) & ~ready;
  endtask

  task automatic check_held(input string tag);
    check({tag, "_alu_res"}, bus.alu_res, mdl_alu);
    check({tag, "_mem_data"}, bus.mem_data, mdl_data);
    check({tag, "_dest"}, 32'(bus.Dest), 32'(mdl_dest));
  endtask

  // n stall cycles, then (if complete) the ready cycle
  task automatic issue(input logic wb, input logic r, input logic w, input logic [31:0] alu,
                       input logic [31:0] data, input logic [3:0] dest, input int n, input bit complete);
    int unsigned base;
    base = exp_stall;
    for (int i = 0; i < n; i++) begin
      drive(wb, r, w, alu, $urandom, dest, 1'b0);
      @(negedge clk);
      check("freeze_stall", 32'(bus.freeze), 32'd1);
      check("stall_count_run", 32'(bus.stall_count), sat16(base + i));
      check("timeout_run", 32'(bus.mem_timeout), 32'(exp_to || (i >= TIMEOUT)));
      if (i < 3) check_held("hold");
    end
    exp_stall = sat16(base + n);
    if (n >= TIMEOUT) exp_to = 1'b1;
    if (complete) begin
      drive(wb, r, w, alu, data, dest, 1'b1);
      if (wb) exp_q.push_back('{dest: dest, value: (r ? data : alu), mem_r: r});
      @(negedge clk);
      check("freeze_done", 32'(bus.freeze), 32'd0);
      check("stall_count_done", 32'(bus.stall_count), exp_stall);
      check("timeout_done", 32'(bus.mem_timeout), 32'(exp_to));
      check_held("done");
    end
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 1'b1);
    @(negedge clk);
    check("freeze_nop", 32'(bus.freeze), 32'd0);
  endtask

  initial begin
    rst             = 1'b1;
    bus.WB_EN_in    = 1'b0;
    bus.MEM_R_EN_in = 1'b0;
    bus.MEM_W_EN_in = 1'b0;
    bus.alu_res_in  = '0;
    bus.mem_data_in = '0;
    bus.Dest_in     = '0;
    bus.sram_ready  = 1'b1;
    #1;
    check("rst_wb_en", 32'(bus.WB_EN), 32'd0);
    check("rst_mem_r_en", 32'(bus.MEM_R_EN), 32'd0);
    check("rst_wb_value", bus.WB_Value, 32'd0);
    check("rst_dest", 32'(bus.Dest), 32'd0);
    check("rst_stall_count", 32'(bus.stall_count), 32'd0);
    check("rst_timeout", 32'(bus.mem_timeout), 32'd0);
    check("rst_freeze_idle", 32'(bus.freeze), 32'd0);
    // freeze stays combinational while reset is held
    bus.MEM_R_EN_in = 1'b1;
    bus.sram_ready  = 1'b0;
    #1;
    check("rst_freeze_comb", 32'(bus.freeze), 32'd1);
    bus.MEM_R_EN_in = 1'b0;
    bus.sram_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // ALU op, single cycle
    issue(1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'd3, 0, 1'b1);
    // load with 4 stall cycles
    issue(1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 4'd5, 4, 1'b1);
    check("stall_count_load4", 32'(bus.stall_count), 32'd4);
    // store (3 stalls) immediately followed by load (3 stalls)
    issue(1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h1111_1111, 4'd7, 3, 1'b1);
    issue(1'b1, 1'b1, 1'b0, 32'h0000_0204, 32'hCAFE_F00D, 4'd9, 3, 1'b1);
    check("stall_count_b2b", 32'(bus.stall_count), 32'd10);
    // load flushed after 2 stall cycles
    issue(1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'd2, 2, 1'b0);
    nop();
    check("stall_count_flush", 32'(bus.stall_count), 32'd12);
    // long stall crossing TIMEOUT, then completes
    issue(1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h1234_5678, 4'd12, 12, 1'b1);
    nop();
    nop();

    // reset during cycle 2 of a 5-cycle load
    issue(1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h5555_AAAA, 4'd14, 2, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_wb_en", 32'(bus.WB_EN), 32'd0);
    check("mid_rst_alu_res", bus.alu_res, 32'd0);
    check("mid_rst_dest", 32'(bus.Dest), 32'd0);
    check("mid_rst_wb_value", bus.WB_Value, 32'd0);
    check("mid_rst_stall_count", 32'(bus.stall_count), 32'd0);
    check("mid_rst_timeout", 32'(bus.mem_timeout), 32'd0);
    check("mid_rst_freeze", 32'(bus.freeze), 32'd1);
    bus.WB_EN_in    = 1'b0;
    bus.MEM_R_EN_in = 1'b0;
    bus.sram_ready  = 1'b1;
    exp_stall = 0;
    exp_to    = 1'b0;
    mdl_alu   = '0;
    mdl_data  = '0;
    mdl_dest  = '0;
    prev_alu  = '0;
    prev_data = '0;
    prev_dest = '0;
    prev_frz  = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    nop();
    check("post_rst_wb_en", 32'(bus.WB_EN), 32'd0);

    // saturation: 65534 + 3 stall cycles in one access
    issue(1'b1, 1'b1, 1'b0, 32'h0000_0600, 32'h0BAD_F00D, 4'd1, 65537, 1'b1);
    check("stall_count_sat", 32'(bus.stall_count), 32'd65535);
    nop();
    nop();

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL wb_missing actual_pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
